// File: rtl/ula_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic, iterative shift-add multiply and
// restoring division, with a valid/ready handshake and a registered result.
module ula_mc #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         Z,
  output logic         N,
  output logic         C,
  output logic         V,
  output logic         DZ
);

  localparam int CW = $clog2(W);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOT = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd6;
  localparam logic [2:0] OP_REM = 3'd7;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state_reg, state_next;
  logic [2:0]      op_reg;
  logic [W-1:0]    opnd_reg;   // multiplicand or divisor
  logic [W-1:0]    hi_reg;     // partial product high half / partial remainder
  logic [W-1:0]    lo_reg;     // multiplier bits / dividend bits becoming quotient
  logic [CW-1:0]   cnt_reg;
  logic [W-1:0]    y_reg;
  logic            c_reg, v_reg, dz_reg;

  logic            last_iter;
  logic            b_zero;
  logic            quick;
  logic [W:0]      add_full, sub_full;
  logic [W-1:0]    alu_y;
  logic            alu_c, alu_v, alu_dz;

  logic [W:0]      mul_sum;
  logic [W-1:0]    mul_hi_next, mul_lo_next;
  logic [W:0]      r_shift;
  logic            div_ge;
  logic [W-1:0]    div_r_next, div_q_next;

  assign last_iter = (cnt_reg == CW'(W - 1));
  assign b_zero    = (b == '0);
  // Everything except mul and a real division finishes in one cycle.
  assign quick     = (op != OP_MUL) && !(((op == OP_DIV) || (op == OP_REM)) && !b_zero);
  assign add_full  = {1'b0, a} + {1'b0, b};
  assign sub_full  = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_y  = '0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    alu_dz = 1'b0;
    case (op)
      OP_ADD: begin
        alu_y = add_full[W-1:0];
        alu_c = add_full[W];
        alu_v = (a[W-1] == b[W-1]) && (add_full[W-1] != a[W-1]);
      end
      OP_SUB: begin
        alu_y = sub_full[W-1:0];
        alu_c = sub_full[W];
        alu_v = (a[W-1] != b[W-1]) && (sub_full[W-1] != a[W-1]);
      end
      OP_AND: alu_y = a & b;
      OP_OR:  alu_y = a | b;
      OP_NOT: alu_y = ~a;
      OP_DIV: alu_dz = 1'b1;
      OP_REM: begin
        alu_y  = a;
        alu_dz = 1'b1;
      end
      default: alu_y = '0;
    endcase
  end

  // One shift-add step: conditionally add multiplicand, shift {hi,lo} right.
  assign mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
  assign mul_hi_next = mul_sum[W:1];
  assign mul_lo_next = {mul_sum[0], lo_reg[W-1:1]};

  // One restoring step: shift next dividend bit in, subtract if it fits.
  assign r_shift    = {hi_reg, lo_reg[W-1]};
  assign div_ge     = (r_shift >= {1'b0, opnd_reg});
  assign div_r_next = div_ge ? (r_shift[W-1:0] - opnd_reg) : r_shift[W-1:0];
  assign div_q_next = {lo_reg[W-2:0], div_ge};

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) begin
        if (op == OP_MUL)  state_next = MUL;
        else if (!quick)   state_next = DIV;
        else               state_next = DONE;
      end
      MUL:  if (last_iter) state_next = DONE;
      DIV:  if (last_iter) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg   <= OP_ADD;
      opnd_reg <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      cnt_reg  <= '0;
      y_reg    <= '0;
      c_reg    <= 1'b0;
      v_reg    <= 1'b0;
      dz_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          op_reg   <= op;
          cnt_reg  <= '0;
          hi_reg   <= '0;
          opnd_reg <= (op == OP_MUL) ? a : b;
          lo_reg   <= (op == OP_MUL) ? b : a;
          if (quick) begin
            y_reg  <= alu_y;
            c_reg  <= alu_c;
            v_reg  <= alu_v;
            dz_reg <= alu_dz;
          end
        end
        MUL: begin
          hi_reg  <= mul_hi_next;
          lo_reg  <= mul_lo_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_iter) begin
            y_reg  <= mul_lo_next;
            c_reg  <= |mul_hi_next;
            v_reg  <= 1'b0;
            dz_reg <= 1'b0;
          end
        end
        DIV: begin
          hi_reg  <= div_r_next;
          lo_reg  <= div_q_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_iter) begin
            y_reg  <= (op_reg == OP_DIV) ? div_q_next : div_r_next;
            c_reg  <= 1'b0;
            v_reg  <= 1'b0;
            dz_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign y  = y_reg;
  assign Z  = (y_reg == '0);
  assign N  = y_reg[W-1];
  assign C  = c_reg;
  assign V  = v_reg;
  assign DZ = dz_reg;

endmodule

// File: tb/tb_ula_mc.sv
// Directed-vector bench for ula_mc (W=32): results, flags, latency,
// backpressure, reset behaviour. Flags are compared as {Z,N,C,V,DZ}.
module tb_ula_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        Z, N, C, V, DZ;

  int checks   = 0;
  int failures = 0;

  ula_mc #(.W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .Z(Z), .N(N), .C(C), .V(V), .DZ(DZ)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Present one request, wait for acceptance, then for out_valid (bounded).
  // lat = 1 means out_valid is seen in the cycle right after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] z,
                       output int lat);
    op = o; a = x; b = z; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    $display("txn op=%0d a=%h b=%h lat=%0d y=%h flags=%b", o, x, z, lat, y, {Z, N, C, V, DZ});
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready, y, Z, N, C, V, DZ} !== {1'b0, 1'b1, 32'h0, 5'b10000}) begin
      failures++;
      $display("FAIL reset_state got ov=%b ir=%b y=%h f=%b exp ov=0 ir=1 y=0 f=10000",
               out_valid, in_ready, y, {Z, N, C, V, DZ});
    end
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL reset_release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  // Vector table: op, a, b, expected y, expected {Z,N,C,V,DZ}, expected latency.
  task automatic test_vectors();
    logic [2:0]  v_op  [19];
    logic [31:0] v_a   [19];
    logic [31:0] v_b   [19];
    logic [31:0] v_y   [19];
    logic [4:0]  v_f   [19];
    int          v_lat [19];
    int lat;
    v_op = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5,
             3'd5, 3'd6, 3'd7, 3'd6, 3'd7, 3'd6, 3'd7, 3'd6, 3'd7};
    v_a  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd7, 32'h80000000, 32'hF0F01234,
             32'hF0F01234, 32'h0, 32'h10000, 32'd3, 32'hFFFFFFFF, 32'd100, 32'd100,
             32'd9, 32'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd5};
    v_b  = '{32'd1, 32'd1, 32'd7, 32'd7, 32'd1, 32'h0FF0FF00, 32'h0FF0FF00, 32'h1234,
             32'h10000, 32'd7, 32'hFFFFFFFF, 32'd7, 32'd7, 32'd0, 32'd0, 32'd1, 32'd1,
             32'd9, 32'd9};
    v_y  = '{32'h80000000, 32'h0, 32'hFFFFFFFE, 32'h0, 32'h7FFFFFFF, 32'h00F01200,
             32'hFFF0FF34, 32'hFFFFFFFF, 32'h0, 32'd21, 32'd1, 32'd14, 32'd2, 32'd0,
             32'd9, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd5};
    v_f  = '{5'b01010, 5'b10100, 5'b01100, 5'b10000, 5'b00010, 5'b00000, 5'b01000,
             5'b01000, 5'b10100, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b10001,
             5'b00001, 5'b01000, 5'b10000, 5'b10000, 5'b00000};
    v_lat = '{1, 1, 1, 1, 1, 1, 1, 1, 33, 33, 33, 33, 33, 1, 1, 33, 33, 33, 33};
    for (int i = 0; i < 19; i++) begin
      issue(v_op[i], v_a[i], v_b[i], lat);
      checks++;
      if (lat !== v_lat[i]) begin
        failures++;
        $display("FAIL latency[%0d] got=%0d exp=%0d", i, lat, v_lat[i]);
      end
      checks++;
      if ({y, Z, N, C, V, DZ} !== {v_y[i], v_f[i]}) begin
        failures++;
        $display("FAIL result[%0d] got y=%h f=%b exp y=%h f=%b", i, y, {Z, N, C, V, DZ},
                 v_y[i], v_f[i]);
      end
      consume();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        failures++;
        $display("FAIL handshake[%0d] got ov=%b ir=%b exp ov=0 ir=1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(3'd0, 32'd2, 32'd3, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0); op = 3'd0; a = 32'd100; b = 32'd100;
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, y, Z, N, C, V, DZ} !== {1'b1, 1'b0, 32'd5, 5'b00000}) begin
        failures++;
        $display("FAIL hold[%0d] got ov=%b ir=%b y=%h f=%b exp ov=1 ir=0 y=5 f=00000",
                 i, out_valid, in_ready, y, {Z, N, C, V, DZ});
      end
    end
    // Request present in the handshake cycle must be ignored.
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready, y} !== {1'b0, 1'b1, 32'd5}) begin
      failures++;
      $display("FAIL no_accept got ov=%b ir=%b y=%h exp ov=0 ir=1 y=5", out_valid, in_ready, y);
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    int seen = 0;
    op = 3'd5; a = 32'd1234; b = 32'd5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready, y, Z} !== {1'b0, 1'b1, 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL mul_abort got ov=%b ir=%b y=%h Z=%b exp ov=0 ir=1 y=0 Z=1",
               out_valid, in_ready, y, Z);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL mul_abort_no_result got=%0d valid cycles exp=0", seen);
    end
    issue(3'd0, 32'd2, 32'd3, lat);
    checks++;
    if ({lat, y, Z, N, C, V, DZ} !== {32'sd1, 32'd5, 5'b00000}) begin
      failures++;
      $display("FAIL post_reset_add got lat=%0d y=%h f=%b exp lat=1 y=5 f=00000",
               lat, y, {Z, N, C, V, DZ});
    end
    consume();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; a = '0; b = '0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
